// File: rtl/result_buffer.sv
// Pairs two consecutive adder sums (lower, then upper) into one wide result word held for the SRAM writer.
// Optional RESULT_BUFFER_CARRY_CHAIN_EN feeds the stored lower-half carry back to the adder as carry_o.
module result_buffer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int CNT_W         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        result_i,
  input  logic                     carry_i,
  input  logic                     buffer_write,
  input  logic                     buffer_control,
  output logic [MEM_WORD_SIZE-1:0] buff_result,
  output logic                     word_valid_o,
  output logic                     overflow_o,
  output logic                     proto_err_o,
  output logic [CNT_W-1:0]         word_count_o,
  output logic                     carry_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    LOW   = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        lower_q, lower_d;
  logic [MEM_WORD_SIZE-1:0] buff_q, buff_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;
  logic                     perr_q, perr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
`ifdef RESULT_BUFFER_CARRY_CHAIN_EN
  logic                     low_carry_q, low_carry_d;
`endif

  // buffer_write is active-low: a strobe is a cycle with buffer_write == 0.
  always_comb begin
    // NOTE: every next-state signal defaults to its register first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    lower_d = lower_q;
    buff_d  = buff_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    perr_d  = perr_q;
    cnt_d   = cnt_q;
`ifdef RESULT_BUFFER_CARRY_CHAIN_EN
    low_carry_d = low_carry_q;
`endif
    if (!buffer_write) begin
      if (!buffer_control) begin
        // A repeated lower capture simply replaces the pending half.
        state_d = LOW;
        lower_d = result_i;
        valid_d = 1'b0;
`ifdef RESULT_BUFFER_CARRY_CHAIN_EN
        low_carry_d = carry_i;
`endif
      end else if (state_q == LOW) begin
        state_d = EMPTY;
        buff_d  = {result_i, lower_q};
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (carry_i) ovf_d = 1'b1;
      end else begin
        // Upper half with nothing to pair it with: drop the data, flag it.
        perr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= EMPTY;
      lower_q <= '0;
      buff_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lower_q <= lower_d;
      buff_q  <= buff_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RESULT_BUFFER_CARRY_CHAIN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) low_carry_q <= 1'b0;
    else       low_carry_q <= low_carry_d;
  end

  // Carry-in for the upper add is only meaningful while its lower half is pending.
  assign carry_o = (state_q == LOW) && low_carry_q;
`else
  assign carry_o = 1'b0;
`endif

  assign buff_result  = buff_q;
  assign word_valid_o = valid_q;
  assign overflow_o   = ovf_q;
  assign proto_err_o  = perr_q;
  assign word_count_o = cnt_q;

endmodule

// File: doc/result_buffer.md
Name: result_buffer

Overview:
- Sits directly downstream of the 32-bit adder and upstream of the SRAM write path in the calculator datapath.
- Assembles two consecutive 32-bit adder sums (lower half first, then upper half) into one MEM_WORD_SIZE-bit result word.
- Holds each completed word stable in an output register while the controller writes it to SRAM A (bits 31:0) and SRAM B (bits 63:32).
- Tracks protocol errors, arithmetic overflow and the number of completed words.

Parameters:
- DATA_W, 32, width of one adder sum / one buffer half.
- MEM_WORD_SIZE, 64, width of the assembled result word; must equal 2*DATA_W.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- rst_i  input  1  reset, synchronous, active-high.
- result_i  input  DATA_W  sum from the adder.
- carry_i  input  1  carry-out of the adder for result_i.
- buffer_write  input  1  active-low capture strobe; 0 = capture result_i this cycle.
- buffer_control  input  1  half select; 1 = upper, 0 = lower.
- buff_result  output  MEM_WORD_SIZE  last completed word {upper, lower}.
- word_valid_o  output  1  buff_result holds a completed, unconsumed-by-new-lower word.
- overflow_o  output  1  sticky; carry out of the upper half seen.
- proto_err_o  output  1  sticky; upper capture attempted with no pending lower half.
- word_count_o  output  CNT_W  number of completed words since reset; wraps.
- carry_o  output  1  carry-in for the adder's upper-half add (see Optional Feature).

Behaviour:
- Reset (rst_i=1 at posedge): state EMPTY, assembly register 0, buff_result 0, word_valid_o 0, overflow_o 0, proto_err_o 0, word_count_o 0, carry_o 0, stored lower carry 0. Reset mid-assembly discards the pending lower half.
- FSM states: EMPTY (no pending half), LOW (lower half captured, upper pending).
- Capture happens only on cycles where buffer_write==0. When buffer_write==1, all registers hold.
- Lower capture (buffer_control=0):
  - Result goes to the assembly lower register; carry_i goes to the stored lower carry.
  - Next state is LOW from either EMPTY or LOW. A repeat lower capture in LOW overwrites the pending half; no error is flagged.
  - word_valid_o clears on the same edge. buff_result keeps its previous value.
- Upper capture (buffer_control=1) in LOW:
  - buff_result <= {result_i, assembly lower} on that edge. Latency is 1 cycle from the strobe to the new buff_result.
  - word_valid_o <= 1; word_count_o <= word_count_o+1, wrapping from all-ones to 0; next state EMPTY.
  - overflow_o is set if carry_i==1 on this capture.
- Upper capture in EMPTY:
  - Data is ignored; buff_result and word_valid_o hold.
  - proto_err_o <= 1 (sticky until reset); state stays EMPTY.
- word_valid_o stays high until the next lower capture or reset. The controller samples buff_result in the cycle after the upper capture.
- Sticky flags clear only on reset.
- Back-to-back strobes are legal, i.e. lower, upper, lower, upper on consecutive cycles. No stall or backpressure exists; the block always accepts.

Optional Feature:
- Macro: RESULT_BUFFER_CARRY_CHAIN_EN.
- Defined:
  - carry_o = stored lower carry while state==LOW; otherwise 0.
  - The adder uses carry_o as carry-in for the upper-half add, so buff_result is a true MEM_WORD_SIZE-bit sum.
  - overflow_o reflects the final carry out of bit MEM_WORD_SIZE-1.
- Not defined:
  - carry_o is tied 0 and the stored lower carry is not instantiated.
  - The halves are independent 32-bit sums.
  - overflow_o still captures carry_i on upper captures.

Test Plan:
- Basic assembly: reset; lower capture result_i=0x0000_0005; next cycle upper capture result_i=0x0000_0007. Required: the following cycle buff_result=0x0000_0007_0000_0005, word_valid_o=1, word_count_o=1.
- Protocol error: after reset, upper capture result_i=0xDEAD_BEEF. Required: proto_err_o=1, buff_result=0, word_valid_o=0, word_count_o=0.
- Lower overwrite and hold:
  - Lower 0x1, lower 0x2, idle 3 cycles (buffer_write=1), upper 0x3.
  - Required: buff_result=0x0000_0003_0000_0002. word_valid_o drops after the first lower capture and stays low until the upper capture.
- Carry path, with RESULT_BUFFER_CARRY_CHAIN_EN defined:
  - Lower capture result_i=0xFFFF_FFFF with carry_i=1. Required: carry_o=1 in the next cycle.
  - Then upper capture with carry_i=1. Required: overflow_o=1 and carry_o=0.
  - With the macro undefined, the same stimulus must give carry_o=0 throughout.
- Counter wrap: with CNT_W=2, complete 5 words back-to-back. Required: word_count_o sequence 1,2,3,0,1.
- Reset mid-operation: lower capture 0xAAAA_AAAA, assert rst_i for 1 cycle, then upper capture 0x1. Required: proto_err_o=1, buff_result=0, all other outputs at reset values.
